bcd_counter_ctrl: RTL and testbench
===================================

// Module: bcd_counter_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the 3-digit BCD counter chain (units/tens/hundreds).
//  - Generates a prescaled count-enable pulse.
//  - Issues synchronous clears.
//  - Compares the live count against a BCD target and stops on a hit.
//  - Latches lap snapshots.
//  - Sits between the button/host logic and the counter chain's enable and clear inputs.
// PARAMETERS
//  PRESCALE   1000   Clock cycles per count tick; legal range >= 1 (1 = tick every cycle)
// PORTS
//  Clock      in   1   system clock, all state on rising edge
//  nReset     in   1   asynchronous, active-low reset
//  Start      in   1   one-cycle pulse, pre-synchronised: run / resume
//  Stop       in   1   one-cycle pulse: pause
//  Clear      in   1   one-cycle pulse: abort and zero the count
//  Lap        in   1   one-cycle pulse: snapshot the live count
//  Target     in   12  BCD target {hundreds,tens,units}; a digit >9 means the target never hits
//  Co1/Co10/Co100 in 4 each  live BCD digits fed back from the counter chain
//  CntEn      out  1   count-enable pulse to the units counter
//  CntClr     out  1   one-cycle synchronous clear to the counter chain
//  Done       out  1   level; high in DONE
//  Running    out  1   level; high in RUN
//  LapValue   out  12  last lap snapshot {Co100,Co10,Co1}
//  LapValid   out  1   high once a lap has been taken since the last clear
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; prescaler 0.
//  - States: IDLE, RUN, PAUSE, DONE.
//  - Command priority within a cycle: Clear > Stop > Start; Lap is independent but loses to Clear.
//  - Transitions:
//    - Clear, any state -> IDLE. In that cycle: CntClr=1, prescaler<=0, LapValid<=0, LapValue<=0.
//    - IDLE/PAUSE + Start -> RUN. Prescaler keeps its value on resume; it is 0 after a clear.
//    - RUN + Stop -> PAUSE. The prescaler freezes.
//    - RUN + hit -> DONE.
//    - DONE ignores Start and Stop; only Clear leaves DONE.
//  - Hit is combinational: {Co100,Co10,Co1} == Target while in RUN.
//  - Prescaler:
//    - Counts 0..PRESCALE-1 only in RUN.
//    - tick = (PreCnt == PRESCALE-1); PreCnt wraps to 0 on tick.
//  - CntEn = tick & RUN & ~hit & ~Stop & ~Clear.
//    - A hit suppresses CntEn in the same cycle, so the count freezes exactly at Target.
//    - Digits update 1 cycle after a CntEn pulse. The hit is seen that cycle; DONE follows 1 cycle later.
//  - Target 000 with count 000: Start -> RUN for 1 cycle, then DONE, with no CntEn.
//  - Count 999 without a hit wraps to 000 in the counter chain; the controller keeps running.
//  - Lap in RUN or PAUSE:
//    - LapValue <= live digits; LapValid <= 1.
//    - Lap in IDLE or DONE is ignored.
//  - Target may change at any time; the compare always uses the current value.
//  - nReset asserted mid-run returns to the reset state immediately. The counter chain shares nReset.
// CONFIGURATION
//  AUTO_RELOAD_EN
//  - Defined: a hit in RUN does not enter DONE. Instead:
//    - CntClr=1 for that cycle, Done pulses high for 1 cycle, state stays RUN.
//    - The prescaler restarts at 0. The count restarts from 000.
//    - Exception: Target == 000 behaves as when undefined (enters DONE).
//  - Undefined: behaviour as above; Done is a level in DONE.
// STRUCTURE
//  - Package bcd_ctrl_pkg:
//    - typedef ctrl_state_t enum {IDLE,RUN,PAUSE,DONE}
//    - typedef bcd3_t logic[11:0]
//    - localparam BCD_MAX = 12'h999
//  - Sub-module tick_prescaler:
//    - Parameter PRESCALE.
//    - Inputs: run, restart. Output: tick.
//    - Counter width $clog2(PRESCALE), minimum 1.
//  - FSM, compare, CntEn gating and lap register live in the top.
// TESTING
//  1. Reset, then Start with PRESCALE=4, Target=12'h015 -> CntEn every 4th cycle; count reaches 015; DONE 1 cycle after the hit; no further CntEn.
//  2. RUN at count 007, Stop, wait 20 cycles, Start -> no CntEn while paused; ticks resume with the remaining prescaler phase; count continues 008.
//  3. Lap at count 042 in RUN, then Clear -> LapValue=12'h042 and LapValid=1; Clear zeroes both; CntClr pulses 1 cycle; state IDLE.
//  4. Start+Stop+Clear in the same cycle from PAUSE -> IDLE with CntClr=1; Start and Stop have no effect.
//  5. Target=12'h0A0, PRESCALE=1, run 1000 cycles -> count wraps 999->000; never DONE.
//  6. With AUTO_RELOAD_EN, Target=12'h003 -> count sequence 0,1,2,3,0,1...; Done 1-cycle pulse at each 3; Running stays 1.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the 3-digit BCD counter controller.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } ctrl_state_t;

  typedef logic [11:0] bcd3_t;

  localparam bcd3_t BCD_MAX = 12'h999;

  // A target with any digit above 9 can never match a live BCD count.
  function automatic logic is_bcd3(input bcd3_t value);
    return (value[3:0] <= BCD_MAX[3:0]) &&
           (value[7:4] <= BCD_MAX[7:4]) &&
           (value[11:8] <= BCD_MAX[11:8]);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-PRESCALE counter; tick marks the last cycle of each period.
module tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Run/pause/clear sequencer for a 3-digit BCD counter chain with target stop and lap capture.
// Build option: define AUTO_RELOAD_EN to restart from 000 on a hit instead of stopping in DONE.
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Clear,
  input  logic        Lap,
  input  logic [11:0] Target,
  input  logic [3:0]  Co1,
  input  logic [3:0]  Co10,
  input  logic [3:0]  Co100,
  output logic        CntEn,
  output logic        CntClr,
  output logic        Done,
  output logic        Running,
  output logic [11:0] LapValue,
  output logic        LapValid
);

  ctrl_state_t state;
  bcd3_t       live;
  logic        in_run;
  logic        hit;
  logic        reload;
  logic        pre_run;
  logic        tick;

  assign live   = {Co100, Co10, Co1};
  assign in_run = (state == RUN);
  assign hit    = in_run && is_bcd3(Target) && (live == Target);

`ifdef AUTO_RELOAD_EN
  // Target 000 would re-hit immediately after the clear, so it stops in DONE instead.
  assign reload = hit && (Target != '0) && !Stop && !Clear;
`else
  assign reload = 1'b0;
`endif

  // The prescaler also holds in the Stop cycle so a resume continues the exact phase.
  assign pre_run = in_run && !hit && !Stop && !Clear;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (Clock),
    .rst_n   (nReset),
    .run     (pre_run),
    .restart (Clear || reload),
    .tick    (tick)
  );

  assign CntEn   = tick && pre_run;
  assign CntClr  = Clear || reload;
  assign Done    = (state == DONE) || reload;
  assign Running = in_run;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else if (Clear) begin
      state <= IDLE;
    end else if (Stop) begin
      if (state == RUN) state <= PAUSE;
    end else begin
      case (state)
        IDLE, PAUSE: if (Start) state <= RUN;
        RUN:         if (hit && !reload) state <= DONE;
        default:     state <= state;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      LapValue <= '0;
      LapValid <= 1'b0;
    end else if (Clear) begin
      LapValue <= '0;
      LapValid <= 1'b0;
    end else if (Lap && (state == RUN || state == PAUSE)) begin
      LapValue <= live;
      LapValid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed bench for bcd_counter_ctrl with a behavioural BCD counter chain per instance.
module tb_bcd_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, clear, lap;
  logic [11:0] target;

  logic        en4, clr4, done4, run4, lapok4;
  logic [11:0] lapv4, cnt4;
  logic        en1, clr1, done1, run1, lapok1;
  logic [11:0] lapv1, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_counter_ctrl #(.PRESCALE(4)) u4 (
    .Clock(clk), .nReset(rst_n), .Start(start), .Stop(stop), .Clear(clear), .Lap(lap),
    .Target(target), .Co1(cnt4[3:0]), .Co10(cnt4[7:4]), .Co100(cnt4[11:8]),
    .CntEn(en4), .CntClr(clr4), .Done(done4), .Running(run4),
    .LapValue(lapv4), .LapValid(lapok4)
  );

  bcd_counter_ctrl #(.PRESCALE(1)) u1 (
    .Clock(clk), .nReset(rst_n), .Start(start), .Stop(stop), .Clear(clear), .Lap(lap),
    .Target(target), .Co1(cnt1[3:0]), .Co10(cnt1[7:4]), .Co100(cnt1[11:8]),
    .CntEn(en1), .CntClr(clr1), .Done(done1), .Running(run1),
    .LapValue(lapv1), .LapValid(lapok1)
  );

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] u, t, h;
    u = v[3:0]; t = v[7:4]; h = v[11:8];
    if (u != 4'd9) u = u + 4'd1;
    else begin
      u = 4'd0;
      if (t != 4'd9) t = t + 4'd1;
      else begin
        t = 4'd0;
        h = (h != 4'd9) ? h + 4'd1 : 4'd0;
      end
    end
    return {h, t, u};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt4 <= '0;
      cnt1 <= '0;
    end else begin
      if (clr4) cnt4 <= '0; else if (en4) cnt4 <= bcd_inc(cnt4);
      if (clr1) cnt1 <= '0; else if (en1) cnt1 <= bcd_inc(cnt1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int first_en, last_en, n_en, gap_ok, done_k, hit_run, paused_en, found;
    int done_seen, stopped, wrap_k;
    logic [11:0] hit_cnt, prev;

    rst_n = 1'b0; start = 0; stop = 0; clear = 0; lap = 0; target = 12'h015;
    cyc();
    check("reset_cnten", en4, 0);
    check("reset_cntclr", clr4, 0);
    check("reset_done", done4, 0);
    check("reset_running", run4, 0);
    check("reset_lapvalue", lapv4, 0);
    check("reset_lapvalid", lapok4, 0);
    rst_n = 1'b1;
    cyc();

    // Test 1: PRESCALE=4 run to target 015
    start = 1; cyc(); start = 0;
    first_en = -1; last_en = -1; n_en = 0; gap_ok = 1; done_k = -1; hit_run = 0; hit_cnt = '0;
    for (int k = 1; k <= 100 && done_k < 0; k++) begin
      if (en4) begin
        if (last_en >= 0 && k - last_en != 4) gap_ok = 0;
        if (first_en < 0) first_en = k;
        last_en = k;
        n_en++;
      end
      if (k == 61) begin hit_cnt = cnt4; hit_run = run4; end
      if (done4) done_k = k; else cyc();
    end
    check("t1_first_en", first_en, 4);
    check("t1_last_en", last_en, 60);
    check("t1_en_count", n_en, 15);
    check("t1_en_spacing", gap_ok, 1);
    check("t1_hit_count", hit_cnt, 12'h015);
    check("t1_running_at_hit", hit_run, 1);
`ifdef AUTO_RELOAD_EN
    check("t1_done_pulse_cycle", done_k, 61);
    check("t1_reload_clr", clr4, 1);
    cyc();
    check("t1_reload_count", cnt4, 12'h000);
    check("t1_reload_running", run4, 1);
    check("t1_reload_done_low", done4, 0);
`else
    check("t1_done_cycle", done_k, 62);
    n_en = 0;
    repeat (10) begin if (en4) n_en++; cyc(); end
    check("t1_no_en_in_done", n_en, 0);
    check("t1_count_frozen", cnt4, 12'h015);
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    check("t1_done_ignores_cmds", done4, 1);
    check("t1_done_not_running", run4, 0);
    lap = 1; cyc(); lap = 0;
    check("t1_lap_ignored_done", lapok4, 0);
`endif

    // Test 2: pause at 007 mid-phase, resume keeps remaining phase
    clear = 1; #1;
    check("t2_clear_cntclr", clr4, 1);
    cyc(); clear = 0; target = 12'h0A0;
    check("t2_cleared_count", cnt4, 12'h000);
    start = 1; cyc(); start = 0;
    repeat (29) cyc();
    check("t2_count_007", cnt4, 12'h007);
    stop = 1; cyc(); stop = 0;
    check("t2_paused", run4, 0);
    paused_en = 0;
    repeat (20) begin if (en4) paused_en++; cyc(); end
    check("t2_no_en_paused", paused_en, 0);
    check("t2_count_held", cnt4, 12'h007);
    start = 1; cyc(); start = 0;
    check("t2_resume_j1", en4, 0);
    cyc();
    check("t2_resume_j2", en4, 0);
    cyc();
    check("t2_resume_j3", en4, 1);
    cyc();
    check("t2_count_008", cnt4, 12'h008);

    // Test 3: lap at 042, then clear
    clear = 1; cyc(); clear = 0;
    lap = 1; cyc(); lap = 0;
    check("t3_lap_ignored_idle", lapok4, 0);
    start = 1; cyc(); start = 0;
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      if (cnt4 == 12'h042) found = 1; else cyc();
    end
    check("t3_reached_042", found, 1);
    lap = 1; cyc(); lap = 0;
    check("t3_lapvalue", lapv4, 12'h042);
    check("t3_lapvalid", lapok4, 1);
    clear = 1; #1;
    check("t3_cntclr", clr4, 1);
    cyc(); clear = 0;
    check("t3_cntclr_one_cycle", clr4, 0);
    check("t3_lapvalue_zero", lapv4, 12'h000);
    check("t3_lapvalid_zero", lapok4, 0);
    check("t3_idle", run4, 0);
    check("t3_count_zero", cnt4, 12'h000);

    // Test 4: Start+Stop+Clear together from PAUSE
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    stop = 1; cyc(); stop = 0;
    check("t4_paused", run4, 0);
    start = 1; stop = 1; clear = 1; #1;
    check("t4_cntclr", clr4, 1);
    check("t4_no_en", en4, 0);
    cyc(); start = 0; stop = 0; clear = 0;
    check("t4_not_running", run4, 0);
    check("t4_count_zero", cnt4, 12'h000);
    lap = 1; cyc(); lap = 0;
    check("t4_is_idle_lap_ignored", lapok4, 0);

    // Target 000 with count 000: one RUN cycle, then DONE
    target = 12'h000;
    start = 1; cyc(); start = 0;
    check("tz_running", run4, 1);
    check("tz_no_en", en4, 0);
    check("tz_not_done_yet", done4, 0);
    cyc();
    check("tz_done", done4, 1);
    check("tz_stopped", run4, 0);

    // Test 5: PRESCALE=1 wraps 999 -> 000 and never stops
    clear = 1; cyc(); clear = 0; target = 12'h0A0;
    start = 1; cyc(); start = 0;
    done_seen = 0; stopped = 0; wrap_k = -1; prev = '0;
    for (int k = 1; k <= 1005; k++) begin
      if (done1) done_seen = 1;
      if (!run1) stopped = 1;
      if (prev == 12'h999 && cnt1 == 12'h000) wrap_k = k;
      prev = cnt1;
      cyc();
    end
    check("t5_wrap_cycle", wrap_k, 1001);
    check("t5_never_done", done_seen, 0);
    check("t5_kept_running", stopped, 0);

`ifdef AUTO_RELOAD_EN
    // Test 6: auto reload at target 003
    begin
      int d1, d2, n_done, notrun, clr_miss;
      clear = 1; cyc(); clear = 0; target = 12'h003;
      start = 1; cyc(); start = 0;
      d1 = -1; d2 = -1; n_done = 0; notrun = 0; clr_miss = 0;
      for (int k = 1; k <= 30; k++) begin
        if (!run4) notrun = 1;
        if (done4) begin
          if (n_done == 0) d1 = k; else if (n_done == 1) d2 = k;
          n_done++;
          if (!clr4) clr_miss = 1;
        end
        cyc();
      end
      check("t6_first_done", d1, 13);
      check("t6_second_done", d2, 26);
      check("t6_done_pulses", n_done, 2);
      check("t6_always_running", notrun, 0);
      check("t6_clr_with_done", clr_miss, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
